// File: rtl/universal_seq_shift_reg_pkg.sv
// Purpose : shared mode encoding for the universal sequence shift register.
// Latency : n/a (types and constants only).
// Backpress: n/a.
//
// Johnson validity rule used throughout:
//   code(k), k in 0..WIDTH         : k ones filling up from the LSB
//   code(k), k in WIDTH+1..2*WIDTH-1: ones in the top 2*WIDTH-k bits, zeros below
//   A register value is a valid Johnson state only when it equals code(k) for
//   some k < Leff, where Leff = seq_len if 2 <= seq_len <= 2*WIDTH, else 2*WIDTH.
//   All 2*WIDTH codes are distinct, so each valid value has exactly one index.
package universal_seq_shift_reg_pkg;

  localparam logic [1:0] MODE_HOLD    = 2'b00;
  localparam logic [1:0] MODE_JOHNSON = 2'b01;
  localparam logic [1:0] MODE_RING    = 2'b10;
  localparam logic [1:0] MODE_SERIAL  = 2'b11;

  typedef enum logic [1:0] {
    M_HOLD    = MODE_HOLD,
    M_JOHNSON = MODE_JOHNSON,
    M_RING    = MODE_RING,
    M_SERIAL  = MODE_SERIAL
  } mode_e;

  // Smallest legal programmable Johnson length.
  localparam int MIN_SEQ_LEN = 2;

endpackage

// File: rtl/universal_seq_shift_reg_johnson_codec.sv
// Purpose : Johnson code encoder (two inputs) and decoder (index -> pattern).
// Latency : purely combinational, zero cycles.
// Backpress: none; outputs follow inputs.
//
// Ports:
//   i_leff      effective sequence length, valid indices are 0..i_leff-1
//   i_enc_q     value to encode (current register)  -> o_q_valid, o_q_index
//   i_enc_d     second value checked for validity   -> o_d_valid (load check)
//   i_dec_index index to expand                      -> o_dec_code
module universal_seq_shift_reg_johnson_codec
  import universal_seq_shift_reg_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int LW    = 4
) (
  input  logic [LW-1:0]    i_leff,
  input  logic [WIDTH-1:0] i_enc_q,
  output logic             o_q_valid,
  output logic [LW-1:0]    o_q_index,
  input  logic [WIDTH-1:0] i_enc_d,
  output logic             o_d_valid,
  input  logic [LW-1:0]    i_dec_index,
  output logic [WIDTH-1:0] o_dec_code
);

  // Bit b of code(k): below the fill point while filling (k <= WIDTH),
  // at or above the drain point while draining (k > WIDTH).
  function automatic logic [WIDTH-1:0] code_of(input int k);
    logic [WIDTH-1:0] c;
    c = '0;
    for (int b = 0; b < WIDTH; b++) begin
      c[b] = (k <= WIDTH) ? (b < k) : (b >= k - WIDTH);
    end
    return c;
  endfunction

  logic          w_q_hit;
  logic [LW-1:0] w_q_idx;
  logic          w_d_hit;
  logic [LW-1:0] w_d_idx;

  // Exhaustive match against every code; codes are unique so at most one hits.
  always_comb begin
    w_q_hit = 1'b0;
    w_q_idx = '0;
    w_d_hit = 1'b0;
    w_d_idx = '0;
    for (int k = 0; k < 2*WIDTH; k++) begin
      if (i_enc_q == code_of(k)) begin
        w_q_hit = 1'b1;
        w_q_idx = LW'(k);
      end
      if (i_enc_d == code_of(k)) begin
        w_d_hit = 1'b1;
        w_d_idx = LW'(k);
      end
    end
  end

  // A code beyond the programmed length is treated the same as a non-code.
  assign o_q_valid  = w_q_hit && (w_q_idx < i_leff);
  assign o_q_index  = o_q_valid ? w_q_idx : '0;
  assign o_d_valid  = w_d_hit && (w_d_idx < i_leff);
  assign o_dec_code = code_of(int'(i_dec_index));

endmodule

// File: rtl/universal_seq_shift_reg.sv
// Purpose : multi-mode sequence shift register (Johnson / ring / serial / hold)
//           with parallel load, terminal count and illegal-state correction.
// Latency : q and err update one clk edge after inputs; step and tc are
//           combinational from q and the current control inputs.
// Backpress: none; en=0 stalls the sequence, load always takes effect.
//
// Ports:
//   clk, rst_n  clock (rising edge) and asynchronous active-low reset
//   en          advance enable          mode   00 hold/01 johnson/10 ring/11 serial
//   dir         1 = up/left, 0 = down/right
//   load, d     synchronous parallel load of d (checked in johnson/ring)
//   ser_in      serial input bit        seq_len Johnson length (2..2*WIDTH legal)
//   q           register contents       step   Johnson index of q, 0 if invalid
//   tc          terminal count          err    one-cycle pulse on correction
module universal_seq_shift_reg
  import universal_seq_shift_reg_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int LW    = $clog2(2*WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             ser_in,
  input  logic [LW-1:0]    seq_len,
  output logic [WIDTH-1:0] q,
  output logic [LW-1:0]    step,
  output logic             tc,
  output logic             err
);

  localparam logic [LW-1:0]    FULL_LEN = LW'(2*WIDTH);
  localparam logic [LW-1:0]    MIN_LEN  = LW'(MIN_SEQ_LEN);
  localparam logic [WIDTH-1:0] RING_SEED = WIDTH'(1);

  logic [WIDTH-1:0] r_q;
  logic             r_err;

  mode_e            w_mode;
  logic [LW-1:0]    w_leff;
  logic             w_q_valid;
  logic [LW-1:0]    w_step;
  logic             w_d_valid;
  logic [LW-1:0]    w_j_next_idx;
  logic [WIDTH-1:0] w_j_next_code;
  logic             w_q_onehot;
  logic             w_d_onehot;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_err_nxt;
  logic             w_tc;

  assign w_mode = mode_e'(mode);

  // Out-of-range lengths fall back to the full 2*WIDTH cycle.
  assign w_leff = ((seq_len >= MIN_LEN) && (seq_len <= FULL_LEN)) ? seq_len : FULL_LEN;

  universal_seq_shift_reg_johnson_codec #(
    .WIDTH (WIDTH),
    .LW    (LW)
  ) u_codec (
    .i_leff      (w_leff),
    .i_enc_q     (r_q),
    .o_q_valid   (w_q_valid),
    .o_q_index   (w_step),
    .i_enc_d     (d),
    .o_d_valid   (w_d_valid),
    .i_dec_index (w_j_next_idx),
    .o_dec_code  (w_j_next_code)
  );

  // Next Johnson index, wrapping modulo the effective length.
  always_comb begin
    w_j_next_idx = '0;
    if (dir) begin
      w_j_next_idx = (w_step == w_leff - LW'(1)) ? '0 : w_step + LW'(1);
    end else begin
      w_j_next_idx = (w_step == '0) ? w_leff - LW'(1) : w_step - LW'(1);
    end
  end

  assign w_q_onehot = $onehot(r_q);
  assign w_d_onehot = $onehot(d);

  // Next-state: load wins over stepping; err is a single-cycle pulse so it
  // defaults low and is raised only by a correction in this cycle.
  always_comb begin
    w_q_nxt   = r_q;
    w_err_nxt = 1'b0;
    if (load) begin
      w_q_nxt = d;
      if ((w_mode == M_JOHNSON) && !w_d_valid) begin
        w_q_nxt   = '0;
        w_err_nxt = 1'b1;
      end else if ((w_mode == M_RING) && !w_d_onehot) begin
        w_q_nxt   = RING_SEED;
        w_err_nxt = 1'b1;
      end
    end else if (en) begin
      case (w_mode)
        M_JOHNSON: begin
          // Covers entry from another mode and a seq_len cut below the
          // current index: both land here as an invalid q.
          if (w_q_valid) begin
            w_q_nxt = w_j_next_code;
          end else begin
            w_q_nxt   = '0;
            w_err_nxt = 1'b1;
          end
        end
        M_RING: begin
          if (w_q_onehot) begin
            w_q_nxt = dir ? {r_q[WIDTH-2:0], r_q[WIDTH-1]}
                          : {r_q[0], r_q[WIDTH-1:1]};
          end else begin
            w_q_nxt   = RING_SEED;
            w_err_nxt = 1'b1;
          end
        end
        M_SERIAL: begin
          w_q_nxt = dir ? {r_q[WIDTH-2:0], ser_in}
                        : {ser_in, r_q[WIDTH-1:1]};
        end
        default: begin
          w_q_nxt = r_q;
        end
      endcase
    end
  end

  // Terminal count marks the last state before the wrap in the active direction.
  always_comb begin
    w_tc = 1'b0;
    case (w_mode)
      M_JOHNSON: w_tc = en && w_q_valid &&
                        (dir ? (w_step == w_leff - LW'(1)) : (w_step == '0));
      M_RING:    w_tc = en && w_q_onehot && (dir ? r_q[WIDTH-1] : r_q[0]);
      default:   w_tc = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q   <= '0;
      r_err <= 1'b0;
    end else begin
      r_q   <= w_q_nxt;
      r_err <= w_err_nxt;
    end
  end

  assign q    = r_q;
  assign err  = r_err;
  assign step = w_step;
  assign tc   = w_tc;

endmodule

// File: tb/tb_universal_seq_shift_reg.sv
// Purpose : scoreboard bench for universal_seq_shift_reg (WIDTH=4).
// Latency : expectations pushed at each falling edge, checked 2 time units later.
// Backpress: n/a.
module tb_universal_seq_shift_reg;

  localparam int WIDTH = 4;
  localparam int LW    = $clog2(2*WIDTH) + 1;
  localparam int MASK  = (1 << WIDTH) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic [1:0]       mode;
  logic             dir;
  logic             load;
  logic [WIDTH-1:0] d;
  logic             ser_in;
  logic [LW-1:0]    seq_len;
  logic [WIDTH-1:0] q;
  logic [LW-1:0]    step;
  logic             tc;
  logic             err;

  universal_seq_shift_reg #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .mode    (mode),
    .dir     (dir),
    .load    (load),
    .d       (d),
    .ser_in  (ser_in),
    .seq_len (seq_len),
    .q       (q),
    .step    (step),
    .tc      (tc),
    .err     (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int q;
    int step;
    int tc;
    int err;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   m_q   = 0;
  int   m_err = 0;

  function automatic void chk(string nm, int act, int exp_v);
    n_vec++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
    end
  endfunction

  // Reference model: sequences are built from the written rules directly.
  function automatic int leff_of(int sl);
    return (sl >= 2 && sl <= 2*WIDTH) ? sl : 2*WIDTH;
  endfunction

  function automatic int jcode(int k);
    if (k <= WIDTH) return (1 << k) - 1;
    return MASK - ((1 << (k - WIDTH)) - 1);
  endfunction

  // Index of v within the first L Johnson codes, -1 if absent.
  function automatic int jindex(int v, int lim);
    for (int k = 0; k < lim; k++) begin
      if (jcode(k) == v) return k;
    end
    return -1;
  endfunction

  // Drive one cycle of inputs, record what the DUT must show now, then
  // advance the model to the state after the coming rising edge.
  task automatic cyc(input int en_i, input int mode_i, input int dir_i,
                     input int load_i, input int d_i, input int ser_i,
                     input int sl_i);
    exp_t e;
    int   lim, idx, nq, ne, ones;
    @(negedge clk);
    en = en_i[0]; mode = mode_i[1:0]; dir = dir_i[0]; load = load_i[0];
    d = d_i[WIDTH-1:0]; ser_in = ser_i[0]; seq_len = sl_i[LW-1:0];
    lim  = leff_of(sl_i[LW-1:0]);
    idx  = jindex(m_q, lim);
    ones = $countones(m_q);
    e.q    = m_q;
    e.err  = m_err;
    e.step = (idx < 0) ? 0 : idx;
    e.tc   = 0;
    if (mode_i == 1 && en_i != 0 && idx >= 0)
      e.tc = dir_i[0] ? int'(idx == lim - 1) : int'(idx == 0);
    if (mode_i == 2 && en_i != 0 && ones == 1)
      e.tc = dir_i[0] ? ((m_q >> (WIDTH-1)) & 1) : (m_q & 1);
    sb.push_back(e);
    nq = m_q;
    ne = 0;
    if (load_i != 0) begin
      if (mode_i == 1 && jindex(d_i & MASK, lim) < 0) begin
        nq = 0; ne = 1;
      end else if (mode_i == 2 && $countones(d_i & MASK) != 1) begin
        nq = 1; ne = 1;
      end else begin
        nq = d_i & MASK;
      end
    end else if (en_i != 0) begin
      case (mode_i)
        1: begin
          if (idx < 0) begin
            nq = 0; ne = 1;
          end else begin
            nq = jcode(dir_i[0] ? (idx + 1) % lim : (idx == 0 ? lim - 1 : idx - 1));
          end
        end
        2: begin
          if (ones != 1) begin
            nq = 1; ne = 1;
          end else if (dir_i[0]) begin
            nq = ((m_q << 1) | (m_q >> (WIDTH-1))) & MASK;
          end else begin
            nq = (m_q >> 1) | ((m_q & 1) << (WIDTH-1));
          end
        end
        3: begin
          if (dir_i[0]) nq = ((m_q << 1) | (ser_i & 1)) & MASK;
          else          nq = (m_q >> 1) | ((ser_i & 1) << (WIDTH-1));
        end
        default: nq = m_q;
      endcase
    end
    m_q   = nq;
    m_err = ne;
  endtask

  // Check DUT state right after the edge that follows the last cyc().
  task automatic after_edge(input string nm, input int exp_q, input int exp_err);
    @(posedge clk);
    #1;
    chk({nm, "_q"}, int'(q), exp_q);
    chk({nm, "_err"}, int'(err), exp_err);
  endtask

  // Asynchronous reset inside the current cycle, away from both edges.
  task automatic reset_now(input int exp_pre_q);
    #3;
    chk("pre_rst_q", int'(q), exp_pre_q);
    rst_n = 1'b0;
    #1;
    chk("rst_q", int'(q), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_tc", int'(tc), 0);
    chk("rst_step", int'(step), 0);
    en = 1'b0; load = 1'b0;
    rst_n = 1'b1;
    m_q = 0; m_err = 0;
  endtask

  // Monitor: every cycle the DUT presents q/step/tc/err; compare with the queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_q",    int'(q),    e.q);
        chk("sb_step", int'(step), e.step);
        chk("sb_tc",   int'(tc),   e.tc);
        chk("sb_err",  int'(err),  e.err);
      end
    end
  end

  initial begin
    int cur_mode, held;
    rst_n = 1'b0; en = 1'b0; mode = 2'b00; dir = 1'b1; load = 1'b0;
    d = '0; ser_in = 1'b0; seq_len = LW'(6);
    #12;
    chk("init_q", int'(q), 0);
    chk("init_err", int'(err), 0);
    chk("init_step", int'(step), 0);
    chk("init_tc", int'(tc), 0);
    rst_n = 1'b1;

    // Johnson up, length 6: 0,1,3,7,F,E then wrap; tc only on 1110.
    for (int i = 0; i < 7; i++) cyc(1, 1, 1, 0, 0, 0, 6);
    after_edge("j6_wrap", 1, 0);

    // Johnson down, length 8, from a fresh reset.
    reset_now(1);
    for (int i = 0; i < 8; i++) cyc(1, 1, 0, 0, 0, 0, 8);
    after_edge("j8_down_wrap", 0, 0);

    // Illegal Johnson load then legal one.
    cyc(0, 1, 1, 1, 5, 0, 8);
    after_edge("jload_bad", 0, 1);
    cyc(0, 1, 1, 1, 7, 0, 8);
    after_edge("jload_ok", 7, 0);
    chk("jload_step", int'(step), 3);

    // Ring rotate left from 0010, then correction from 0011.
    cyc(0, 2, 1, 1, 2, 0, 8);
    for (int i = 0; i < 3; i++) cyc(1, 2, 1, 0, 0, 0, 8);
    after_edge("ring_rot", 1, 0);
    cyc(0, 3, 1, 1, 3, 0, 8);
    cyc(1, 2, 1, 0, 0, 0, 8);
    after_edge("ring_fix", 1, 1);

    // Serial shift in 1,0,1,1 then one right shift of 0.
    cyc(0, 3, 1, 1, 0, 0, 8);
    cyc(1, 3, 1, 0, 0, 1, 8);
    cyc(1, 3, 1, 0, 0, 0, 8);
    cyc(1, 3, 1, 0, 0, 1, 8);
    cyc(1, 3, 1, 0, 0, 1, 8);
    after_edge("ser_left", 11, 0);
    cyc(1, 3, 0, 0, 0, 0, 8);
    after_edge("ser_right", 5, 0);

    // Hold with en=0 in serial mode, then reset mid-Johnson at 0111.
    for (int i = 0; i < 3; i++) cyc(0, 3, i & 1, 0, 0, 1, 8);
    after_edge("en0_hold", 5, 0);
    cyc(0, 1, 1, 1, 0, 0, 8);
    for (int i = 0; i < 3; i++) cyc(1, 1, 1, 0, 0, 0, 8);
    cyc(1, 1, 1, 0, 0, 0, 8);
    reset_now(7);

    // Shrinking seq_len under a running Johnson sequence.
    for (int i = 0; i < 6; i++) cyc(1, 1, 1, 0, 0, 0, 8);
    cyc(1, 1, 1, 0, 0, 0, 3);
    cyc(1, 1, 1, 0, 0, 0, 3);

    // Randomized traffic with sticky modes and occasional async resets.
    cur_mode = 1;
    held = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(7) == 0) cur_mode = $urandom_range(3);
      cyc(($urandom_range(3) != 0) ? 1 : 0, cur_mode, $urandom_range(1),
          ($urandom_range(9) == 0) ? 1 : 0, $urandom_range(MASK),
          $urandom_range(1),
          ($urandom_range(3) == 0) ? $urandom_range((1 << LW) - 1) : 2*WIDTH);
      if ($urandom_range(99) == 0) begin
        held = m_q;
        @(posedge clk);
        #1;
        @(negedge clk);
        reset_now(held);
      end
    end

    // Let the monitor drain every queued expectation, with a bound.
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #3;
    if (sb.size() != 0) chk("sb_drain", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/universal_seq_shift_reg.md
Name: universal_seq_shift_reg

Overview:
- Parametrised, multi-mode sequence shift register.
- Generalises the 4-bit fixed 6-state twisted-ring sequencer used in the traffic-light FSMs.
- Johnson mode has programmable sequence length and direction; ring (one-hot) and serial shift modes are added, plus parallel load, terminal-count and illegal-state correction.
- Drives lamp-phase timing and sequencing in traffic-light controllers and similar lab FSM designs.

Parameters:
- WIDTH, 4, register width in bits (>= 2); a full Johnson cycle is 2*WIDTH states.
- LW (derived localparam, not overridable), $clog2(2*WIDTH)+1, width of seq_len and step.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  advance enable; 0 = hold (load still acts).
- mode  in  2  00 HOLD, 01 JOHNSON, 10 RING, 11 SERIAL.
- dir  in  1  1 = up/left, 0 = down/right.
- load  in  1  synchronous parallel load of d.
- d  in  WIDTH  load value.
- ser_in  in  1  serial input bit (SERIAL mode).
- seq_len  in  LW  Johnson sequence length L, legal 2..2*WIDTH.
- q  out  WIDTH  register contents (registered).
- step  out  LW  Johnson index of q (combinational encode); 0 when q is not a valid code.
- tc  out  1  terminal count (combinational).
- err  out  1  registered one-cycle pulse on illegal-state correction or illegal load.

Behaviour:
- Reset: q=0 and err=0 asynchronously. Outputs then read step=0, tc=0.
- Priority each rising edge: load > (en & mode). With en=0 and load=0, q holds and err<=0.
- err defaults to 0 each cycle unless set by a rule below.
- Effective length Leff = seq_len if 2<=seq_len<=2*WIDTH, else 2*WIDTH.

Johnson code for index k:
- k in 0..WIDTH: k ones filling from the LSB.
- k in WIDTH+1..2*WIDTH-1: ones in the top 2*WIDTH-k bits, zeros below.
- WIDTH=4 up sequence: 0000,0001,0011,0111,1111,1110,1100,1000.
- A q is valid only if it is such a code with index < Leff.

JOHNSON mode, en=1:
- Valid q, dir=1: q <= code((step+1) mod Leff).
- Valid q, dir=0: q <= code(step==0 ? Leff-1 : step-1).
- Invalid q: q <= 0 and err <= 1. This applies when switching into JOHNSON with arbitrary contents and when seq_len is reduced mid-run.
- tc = en & mode==JOHNSON & valid & (dir ? step==Leff-1 : step==0).

RING mode, en=1:
- q exactly one-hot: rotate by one (dir=1: MSB wraps to LSB; dir=0: LSB wraps to MSB).
- Otherwise: q <= 1 and err <= 1.
- tc = en & one-hot & (dir ? q[WIDTH-1] : q[0]).

SERIAL mode, en=1:
- dir=1: q <= {q[WIDTH-2:0], ser_in}.
- dir=0: q <= {ser_in, q[WIDTH-1:1]}.
- tc = 0, err stays 0.

HOLD mode:
- q holds; tc = 0.

load=1:
- q <= d regardless of en.
- If mode==JOHNSON and d is not a valid code (per the validity rule above, against Leff): q <= 0 and err <= 1.
- If mode==RING and d is not one-hot: q <= 1 and err <= 1.
- In HOLD and SERIAL, any d is legal.

Mode, dir and seq_len changes take effect on the next edge with no pipeline bubble. Reset asserted mid-sequence clears q immediately.

Decomposition:
- Shared package holds MODE_HOLD/JOHNSON/RING/SERIAL 2-bit constants and the Johnson validity rule comments.
- One natural sub-module: johnson_codec (combinational).
  - encode q -> {valid, index}, with valid also checked against Leff.
  - decode index -> WIDTH-bit pattern.
  - Instantiated once; step mirrors the encoder output.

Test Plan:
1. WIDTH=4, mode=JOHNSON, dir=1, seq_len=6, en=1 from reset. q must cycle 0000,0001,0011,0111,1111,1110,0000, with tc high exactly while q=1110.
2. Same setup with dir=0 and seq_len=8 from reset. q must step 0000,1000,1100,1110,1111,0111,0011,0001,0000, with tc high at each q=0000.
3. mode=JOHNSON with load=1 and d=0101. Next edge q=0000 and err=1 for one cycle. load with d=0111: q=0111, step=3, err=0.
4. mode=RING, dir=1, en=1, load d=0010 then run. q must go 0100,1000,0001. Then switch to RING with q=0011 and en=1: next edge q=0001, err=1.
5. mode=SERIAL, dir=1, ser_in pattern 1,0,1,1 from q=0000. q must reach 1011. With dir=0 and ser_in=0: q=0101. tc and err stay 0.
6. Assert rst_n=0 mid-Johnson with q=0111, away from any clock edge. q must go to 0000 immediately, with err=0 and tc=0. Also run en=0 for 3 cycles in any mode: q must be unchanged.
